riscv_mdu_iter: RTL and testbench

Iterative multiply/divide unit that executes the RV32M operations selected by the decoder's 3-bit MDU opcode. It sits in the execute stage beside the ALU and is instantiated only when `RISCV_M_CORE = 1`. The decoder acts as initiator over a valid/ready request channel; this block responds with a 32-bit result over a valid/ready response channel.

---
 rtl/riscv_mdu_iter.sv | 168 ++++++++++++++++
 tb/tb_riscv_mdu_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/riscv_mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define RISCV_MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiply.
module riscv_mdu_iter #(
  parameter int WORD_WIDTH   = 32,
  parameter int MDU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [MDU_OP_WIDTH-1:0] op_i,
  input  logic [WORD_WIDTH-1:0]   a_i,
  input  logic [WORD_WIDTH-1:0]   b_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WORD_WIDTH-1:0]   result_o,
  output logic [1:0]              dbg_state
);

  localparam int W     = WORD_WIDTH;
  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Handshakes: a request transfers on a rising edge with valid_i && ready_o; a result
  // transfers on a rising edge with valid_o && ready_i. valid_o/result_o hold until taken.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     hi_q, lo_q, opb_q;
  logic [1:0]       op_q;
  logic             sign_a_q, neg_q;
  logic [CNT_W-1:0] cnt_q;

  assign dbg_state = state_q;

  // Request decode: op_i[2] selects divide, op_i[1] remainder, op_i[0] unsigned divide.
  logic         is_div, sa_en, sb_en, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div      = op_i[2];
    sa_en       = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    sb_en       = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    a_neg       = sa_en & a_i[W-1];
    b_neg       = sb_en & b_i[W-1];
    a_mag       = a_neg ? -a_i : a_i;
    b_mag       = b_neg ? -b_i : b_i;
    div_zero    = (b_i == '0);
    div_ovf     = ~op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
    special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN_NEG);
  end

  // One iteration of each datapath; the final iteration also applies sign correction.
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [W-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, quo, rem;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   mul_res, div_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_n = mul_sum[W:1];
    mul_lo_n = {mul_sum[0], lo_q[W-1:1]};
    prod     = {mul_hi_n, mul_lo_n};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = (op_q == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];

    div_sh   = {hi_q, lo_q[W-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh - {1'b0, opb_q};
    div_hi_n = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
    div_lo_n = {lo_q[W-2:0], div_ge};
    quo      = neg_q ? -div_lo_n : div_lo_n;
    rem      = sign_a_q ? -div_hi_n : div_hi_n;
    div_res  = op_q[1] ? rem : quo;
  end

`ifdef RISCV_MDU_FAST_MUL_EN
  logic signed [W:0]       fast_a, fast_b;
  logic signed [2*W+1:0]   fast_prod;
  logic        [W-1:0]     fast_res;

  always_comb begin
    fast_a    = {a_neg, a_i};
    fast_b    = {b_neg, b_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (op_i[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      result_o <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            ready_o  <= 1'b0;
            op_q     <= op_i[1:0];
            sign_a_q <= a_neg;
            neg_q    <= a_neg ^ b_neg;
            cnt_q    <= CNT_W'(W - 1);
            hi_q     <= '0;
            if (is_div) begin
              opb_q <= b_mag;
              lo_q  <= a_mag;
              if (div_zero || div_ovf) begin
                result_o <= special_res;
                valid_o  <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                state_q <= S_DIV;
              end
            end else begin
              opb_q <= a_mag;
              lo_q  <= b_mag;
`ifdef RISCV_MDU_FAST_MUL_EN
              result_o <= fast_res;
              valid_o  <= 1'b1;
              state_q  <= S_DONE;
`else
              state_q  <= S_MUL;
`endif
            end
          end
        end
        S_MUL: begin
          hi_q  <= mul_hi_n;
          lo_q  <= mul_lo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_o <= mul_res;
            valid_o  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          hi_q  <= div_hi_n;
          lo_q  <= div_lo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_o <= div_res;
            valid_o  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mdu_iter.sv
// Self-checking bench for riscv_mdu_iter: directed RV32M cases, backpressure, reset abort,
// and randomized operations against an arithmetic reference model.
module tb_riscv_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_o, valid_o, ready_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, result_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  riscv_mdu_iter dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit and signed-int arithmetic on the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              ia, ib;
    logic [31:0]     q, r;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF; r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = 32'd0;
        end else if (!op[0]) begin
          ia = $signed(a); ib = $signed(b);
          q = ia / ib; r = ia % ib;
        end else begin
          q = a / b; r = a % b;
        end
        return op[1] ? r : q;
      end
    endcase
  endfunction

  // Edges after the accept edge until valid_o is visible.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2])
      return (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 32;
`ifdef RISCV_MDU_FAST_MUL_EN
    return 0;
`else
    return 32;
`endif
  endfunction

  // Driver: issue one request, check latency/result, hold DONE for `hold` cycles, then take it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    int n;
    logic [31:0] e;
    e = ref_result(op, a, b);
    exp_q.push_back(e);
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, " ready_o"}, {31'b0, ready_o}, 32'd1);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, ref_latency(op, a, b));
    check({tag, " valid_o"}, {31'b0, valid_o}, 32'd1);
    check({tag, " result"}, result_o, exp_q.pop_front());
    // A competing request during DONE must be ignored.
    valid_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid_o"}, {31'b0, valid_o}, 32'd1);
      check({tag, " hold result"}, result_o, e);
      check({tag, " hold ready_o"}, {31'b0, ready_o}, 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0; valid_i = 1'b0;
    check({tag, " post valid_o"}, {31'b0, valid_o}, 32'd0);
    check({tag, " post ready_o"}, {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready_o", {31'b0, ready_o}, 32'd1);
    check("reset valid_o", {31'b0, valid_o}, 32'd0);
    check("reset result_o", result_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul 7*-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, "mulh min*min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu max*max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu -1*max");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem -7/2");
    run_op(3'd5, 32'd100, 32'd7, 0, "divu 100/7");
    run_op(3'd7, 32'd100, 32'd7, 10, "remu 100/7 backpressure");
    run_op(3'd4, 32'd5, 32'd0, 0, "div 5/0");
    run_op(3'd6, 32'd5, 32'd0, 0, "rem 5/0");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu 5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem ovf");
    run_op(3'd7, 32'd100, 32'd7, 0, "remu before abort");

    // Abort a DIV mid-iteration.
    valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort ready_o", {31'b0, ready_o}, 32'd1);
    check("abort valid_o", {31'b0, valid_o}, 32'd0);
    check("abort result_o", result_o, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort no result", {31'b0, valid_o}, 32'd0);
    run_op(3'd5, 32'd9, 32'd3, 0, "divu 9/3 after abort");

    // Reset and request in the same cycle: reset wins.
    rst = 1'b1; valid_i = 1'b1; op_i = 3'd4; a_i = 32'd5; b_i = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    check("rst+valid ready_o", {31'b0, ready_o}, 32'd1);
    @(posedge clk); #1;
    check("rst+valid valid_o", {31'b0, valid_o}, 32'd0);
    check("rst+valid idle", {31'b0, ready_o}, 32'd1);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      ra = $urandom; rb = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = $urandom_range(0, 300) - 150; rb = $urandom_range(1, 20); end
      run_op(rop, ra, rb, $urandom_range(0, 2), $sformatf("rand%0d op%0d", k, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
